// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: aligns load data, selects the write-back value,
// flags misaligned loads and counts retired instructions.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   stall, flush   hold / kill stage contents (flush wins)
//   in*            instruction bundle from the memory stage
//   regWrite       register-file write enable
//   writeReg       register-file write address
//   writeData      register-file write data
//   wbValid        stage holds a live instruction
//   addrErr        held instruction was a misaligned load
//   retired        retired-instruction counter (wraps)
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        inValid,
    input  logic        inRegWrite,
    input  logic        inMemToReg,
    input  logic [2:0]  inLoadType,
    input  logic [1:0]  inAddrLow,
    input  logic [31:0] inAluResult,
    input  logic [31:0] inMemData,
    input  logic [4:0]  inWriteReg,
    output logic        regWrite,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData,
    output logic        wbValid,
    output logic        addrErr,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LH  = 3'd1,
        LT_LHU = 3'd2,
        LT_LB  = 3'd3,
        LT_LBU = 3'd4
    } load_e;

    logic        is_lw;
    logic        is_lh;
    logic        is_lhu;
    logic        is_lb;
    logic        is_lbu;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] sel_result;
    logic        misaligned;
    logic        capture;
    logic        retire;

    logic        reg_write_d;
    logic        reg_write_q;
    logic [4:0]  write_reg_d;
    logic [4:0]  write_reg_q;
    logic [31:0] write_data_d;
    logic [31:0] write_data_q;
    logic        wb_valid_d;
    logic        wb_valid_q;
    logic        addr_err_d;
    logic        addr_err_q;
    logic [31:0] retired_d;
    logic [31:0] retired_q;

    // Load-type decode; unused encodings 5-7 behave as LW.
    always_comb begin
        is_lw  = 1'b0;
        is_lh  = 1'b0;
        is_lhu = 1'b0;
        is_lb  = 1'b0;
        is_lbu = 1'b0;
        case (inLoadType)
            LT_LH:   is_lh  = 1'b1;
            LT_LHU:  is_lhu = 1'b1;
            LT_LB:   is_lb  = 1'b1;
            LT_LBU:  is_lbu = 1'b1;
            default: is_lw  = 1'b1;
        endcase
    end

    // Little-endian lane extraction from the aligned memory word.
    always_comb begin
        byte_lane = inMemData[7:0];
        unique case (inAddrLow)
            2'd0: byte_lane = inMemData[7:0];
            2'd1: byte_lane = inMemData[15:8];
            2'd2: byte_lane = inMemData[23:16];
            2'd3: byte_lane = inMemData[31:24];
        endcase
        half_lane = inAddrLow[1] ? inMemData[31:16]
                                 : inMemData[15:0];
    end

    always_comb begin
        load_val = inMemData;
        if (is_lb) begin
            load_val = {{24{byte_lane[7]}}, byte_lane};
        end else if (is_lbu) begin
            load_val = {24'd0, byte_lane};
        end else if (is_lh) begin
            load_val = {{16{half_lane[15]}}, half_lane};
        end else if (is_lhu) begin
            load_val = {16'd0, half_lane};
        end
        sel_result = inMemToReg ? load_val : inAluResult;
    end

    // Byte loads can never be misaligned; bubbles never raise the flag.
    always_comb begin
        misaligned = inMemToReg & inValid &
                     ((is_lw & (inAddrLow != 2'd0)) |
                      ((is_lh | is_lhu) & inAddrLow[0]));
        capture    = ~flush & ~stall;
        retire     = capture & inValid & ~misaligned;
    end

    // Flush beats stall; a stall holds every register, counter included.
    always_comb begin
        reg_write_d  = reg_write_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        wb_valid_d   = wb_valid_q;
        addr_err_d   = addr_err_q;
        retired_d    = retired_q;
        if (flush) begin
            reg_write_d = 1'b0;
            wb_valid_d  = 1'b0;
            addr_err_d  = 1'b0;
        end else if (capture) begin
            wb_valid_d   = inValid;
            write_reg_d  = inWriteReg;
            write_data_d = sel_result;
            addr_err_d   = misaligned;
            reg_write_d  = inValid & inRegWrite &
                           (inWriteReg != 5'd0) & ~misaligned;
        end
        if (retire) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= 32'd0;
            wb_valid_q   <= 1'b0;
            addr_err_q   <= 1'b0;
            retired_q    <= 32'd0;
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            wb_valid_q   <= wb_valid_d;
            addr_err_q   <= addr_err_d;
            retired_q    <= retired_d;
        end
    end

    assign regWrite  = reg_write_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;
    assign wbValid   = wb_valid_q;
    assign addrErr   = addr_err_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table through a
// scoreboard queue, then stall/flush/wrap/reset sequences.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        inValid;
    logic        inRegWrite;
    logic        inMemToReg;
    logic [2:0]  inLoadType;
    logic [1:0]  inAddrLow;
    logic [31:0] inAluResult;
    logic [31:0] inMemData;
    logic [4:0]  inWriteReg;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        wbValid;
    logic        addrErr;
    logic [31:0] retired;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .inValid    (inValid),
        .inRegWrite (inRegWrite),
        .inMemToReg (inMemToReg),
        .inLoadType (inLoadType),
        .inAddrLow  (inAddrLow),
        .inAluResult(inAluResult),
        .inMemData  (inMemData),
        .inWriteReg (inWriteReg),
        .regWrite   (regWrite),
        .writeReg   (writeReg),
        .writeData  (writeData),
        .wbValid    (wbValid),
        .addrErr    (addrErr),
        .retired    (retired)
    );

    typedef struct {
        logic        v;
        logic        rw;
        logic        m2r;
        logic [2:0]  lt;
        logic [1:0]  al;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  wr;
        logic        e_valid;
        logic        e_we;
        logic        e_err;
        logic [31:0] e_data;
        logic        chk_data;
    } vec_t;

    typedef struct {
        logic        valid;
        logic        we;
        logic        err;
        logic [4:0]  wr;
        logic [31:0] data;
        logic        chk_data;
        logic [31:0] ret;
    } exp_t;

    vec_t        tv[$];
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_ret;

    localparam logic [31:0] MW = 32'h80FF_7F01;

    function automatic vec_t mk(
        input logic v, input logic rw, input logic m2r,
        input logic [2:0] lt, input logic [1:0] al,
        input logic [31:0] alu, input logic [31:0] mem,
        input logic [4:0] wr, input logic ev, input logic ew,
        input logic ee, input logic [31:0] ed, input logic cd);
        vec_t t;
        t.v = v; t.rw = rw; t.m2r = m2r; t.lt = lt; t.al = al;
        t.alu = alu; t.mem = mem; t.wr = wr;
        t.e_valid = ev; t.e_we = ew; t.e_err = ee;
        t.e_data = ed; t.chk_data = cd;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw,
                         input logic m2r, input logic [2:0] lt,
                         input logic [1:0] al, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [4:0] wr);
        inValid     = v;
        inRegWrite  = rw;
        inMemToReg  = m2r;
        inLoadType  = lt;
        inAddrLow   = al;
        inAluResult = alu;
        inMemData   = mem;
        inWriteReg  = wr;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_regWrite"},  {31'd0, regWrite}, 32'd0);
        chk({tag, "_writeReg"},  {27'd0, writeReg}, 32'd0);
        chk({tag, "_writeData"}, writeData,         32'd0);
        chk({tag, "_wbValid"},   {31'd0, wbValid},  32'd0);
        chk({tag, "_addrErr"},   {31'd0, addrErr},  32'd0);
        chk({tag, "_retired"},   retired,           32'd0);
    endtask

    initial begin
        exp_t e;
        // ALU path, load lanes, LW aliases, misaligned cases,
        // x0 destination, bubbles and non-writing instructions.
        tv.push_back(mk(1,1,0,0,0,32'h0000_1234,0,5, 1,1,0,32'h0000_1234,1));
        tv.push_back(mk(1,1,1,3,3,0,MW,1, 1,1,0,32'hFFFF_FF80,1));
        tv.push_back(mk(1,1,1,4,2,0,MW,2, 1,1,0,32'h0000_00FF,1));
        tv.push_back(mk(1,1,1,1,2,0,MW,3, 1,1,0,32'hFFFF_80FF,1));
        tv.push_back(mk(1,1,1,2,0,0,MW,4, 1,1,0,32'h0000_7F01,1));
        tv.push_back(mk(1,1,1,3,1,0,MW,6, 1,1,0,32'h0000_007F,1));
        tv.push_back(mk(1,1,1,0,0,0,MW,7, 1,1,0,32'h80FF_7F01,1));
        tv.push_back(mk(1,1,1,5,0,0,MW,9, 1,1,0,32'h80FF_7F01,1));
        tv.push_back(mk(1,1,1,7,1,0,MW,9, 1,0,1,32'h0,0));
        tv.push_back(mk(1,1,1,0,2,0,MW,8, 1,0,1,32'h0,0));
        tv.push_back(mk(1,1,1,1,1,0,MW,10, 1,0,1,32'h0,0));
        tv.push_back(mk(1,1,1,2,3,0,MW,11, 1,0,1,32'h0,0));
        tv.push_back(mk(1,1,1,4,3,0,MW,12, 1,1,0,32'h0000_0080,1));
        tv.push_back(mk(1,1,0,0,0,32'hAAAA_5555,0,0, 1,0,0,32'hAAAA_5555,1));
        tv.push_back(mk(0,1,0,0,0,32'h0000_0005,0,10, 0,0,0,32'h0000_0005,1));
        tv.push_back(mk(0,1,1,0,2,0,MW,10, 0,0,0,32'h0,0));
        tv.push_back(mk(1,0,0,0,0,32'h1357_9BDF,0,13, 1,0,0,32'h1357_9BDF,1));
        tv.push_back(mk(1,1,1,6,0,0,MW,14, 1,1,0,32'h80FF_7F01,1));

        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(0,0,0,0,0,0,0,0);
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ret = 32'd0;

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].v, tv[i].rw, tv[i].m2r, tv[i].lt, tv[i].al,
                  tv[i].alu, tv[i].mem, tv[i].wr);
            if (tv[i].e_valid && !tv[i].e_err) exp_ret = exp_ret + 1;
            e.valid    = tv[i].e_valid;
            e.we       = tv[i].e_we;
            e.err      = tv[i].e_err;
            e.wr       = tv[i].wr;
            e.data     = tv[i].e_data;
            e.chk_data = tv[i].chk_data;
            e.ret      = exp_ret;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_wbValid", i), {31'd0, wbValid},
                    {31'd0, e.valid});
                chk($sformatf("v%0d_regWrite", i), {31'd0, regWrite},
                    {31'd0, e.we});
                chk($sformatf("v%0d_addrErr", i), {31'd0, addrErr},
                    {31'd0, e.err});
                chk($sformatf("v%0d_writeReg", i), {27'd0, writeReg},
                    {27'd0, e.wr});
                chk($sformatf("v%0d_retired", i), retired, e.ret);
                if (e.chk_data)
                    chk($sformatf("v%0d_writeData", i), writeData, e.data);
            end
        end

        // Stall for three cycles while new inputs arrive.
        @(negedge clk);
        drive(1,1,0,0,0,32'hCAFE_0001,0,11);
        @(posedge clk);
        #1;
        exp_ret = exp_ret + 1;
        chk("stall_pre_data", writeData, 32'hCAFE_0001);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            stall = 1'b1;
            drive(1,1,0,0,0,32'hDEAD_0000 + k,0,12);
            @(posedge clk);
            #1;
            chk("stall_regWrite", {31'd0, regWrite}, 32'd1);
            chk("stall_writeReg", {27'd0, writeReg}, 32'd11);
            chk("stall_writeData", writeData, 32'hCAFE_0001);
            chk("stall_wbValid", {31'd0, wbValid}, 32'd1);
            chk("stall_retired", retired, exp_ret);
        end
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        exp_ret = exp_ret + 1;
        chk("unstall_writeReg", {27'd0, writeReg}, 32'd12);
        chk("unstall_writeData", writeData, 32'hDEAD_0002);
        chk("unstall_retired", retired, exp_ret);

        // Misaligned load held, then flush together with stall.
        @(negedge clk);
        drive(1,1,1,0,2,0,MW,8);
        @(posedge clk);
        #1;
        chk("mis_addrErr", {31'd0, addrErr}, 32'd1);
        chk("mis_retired", retired, exp_ret);
        @(negedge clk);
        stall = 1'b1;
        flush = 1'b1;
        drive(1,1,0,0,0,32'h0BAD_0BAD,0,13);
        @(posedge clk);
        #1;
        chk("flush_wbValid", {31'd0, wbValid}, 32'd0);
        chk("flush_regWrite", {31'd0, regWrite}, 32'd0);
        chk("flush_addrErr", {31'd0, addrErr}, 32'd0);
        chk("flush_retired", retired, exp_ret);
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        drive(0,0,0,0,0,0,0,0);

        // Counter wrap: preload the counter while stalled, retire one.
        @(negedge clk);
        stall = 1'b1;
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        stall = 1'b0;
        drive(1,1,0,0,0,32'h0000_0077,0,14);
        @(posedge clk);
        #1;
        exp_ret = 32'd0;
        chk("wrap_retired", retired, exp_ret);
        chk("wrap_regWrite", {31'd0, regWrite}, 32'd1);

        // Asynchronous reset mid-cycle with a write in flight.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        drive(1,1,0,0,0,32'h0000_0099,0,15);
        #1;
        chk_all_zero("arst");
        @(posedge clk);
        #1;
        chk_all_zero("arst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0,1,0,0,0,32'h0000_0042,0,16);
        @(posedge clk);
        #1;
        chk("post_rst_wbValid", {31'd0, wbValid}, 32'd0);
        chk("post_rst_regWrite", {31'd0, regWrite}, 32'd0);
        chk("post_rst_retired", retired, 32'd0);
        @(negedge clk);
        drive(1,1,0,0,0,32'h0000_0042,0,16);
        @(posedge clk);
        #1;
        chk("post_rst_retire", retired, 32'd1);
        chk("post_rst_data", writeData, 32'h0000_0042);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: stall  in  1  hold stage contents.
REQ-004 SHALL have: flush  in  1  kill stage contents.
REQ-005 SHALL have: inValid  in  1  upstream instruction present.
REQ-006 SHALL have: inRegWrite  in  1  instruction writes a register.
REQ-007 SHALL have: inMemToReg  in  1  result from memory (1) or ALU (0).
REQ-008 SHALL have: inLoadType  in  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU; 5-7 decode as LW.
REQ-009 SHALL have: inAddrLow  in  2  load address bits [1:0].
REQ-010 SHALL have: inAluResult  in  32  ALU result.
REQ-011 SHALL have: inMemData  in  32  raw aligned data-memory word.
REQ-012 SHALL have: inWriteReg  in  5  destination register.
REQ-013 SHALL have: regWrite  out  1  register-file write enable.
REQ-014 SHALL have: writeReg  out  5  register-file write address.
REQ-015 SHALL have: writeData  out  32  register-file write data.
REQ-016 SHALL have: wbValid  out  1  stage holds a live instruction.
REQ-017 SHALL have: addrErr  out  1  misaligned-load flag for the held instruction.
REQ-018 SHALL have: retired  out  32  count of retired instructions.

Function
REQ-019 SHALL register all outputs; latency from input capture to output is exactly one clk edge.
REQ-020 On a rising edge with flush=1, SHALL set wbValid=0, regWrite=0, addrErr=0; writeReg/writeData don't-care; flush overrides stall.
REQ-021 On a rising edge with flush=0, stall=1, SHALL hold every output register unchanged, including retired.
REQ-022 On a rising edge with flush=0, stall=0, SHALL capture: wbValid<=inValid; writeReg<=inWriteReg; writeData<=selected result.
REQ-023 Selected result SHALL be inAluResult when inMemToReg=0, else the aligned load value.
REQ-024 Load alignment, little-endian: byte lane = inMemData[8*inAddrLow +: 8]; halfword lane = inMemData[16*inAddrLow[1] +: 16].
REQ-025 LB/LH SHALL sign-extend to 32 bits; LBU/LHU SHALL zero-extend; LW SHALL pass inMemData unchanged.
REQ-026 Misaligned = inMemToReg & inValid & ((LW & inAddrLow!=0) | ((LH|LHU) & inAddrLow[0])); byte loads never misaligned.
REQ-027 On capture, SHALL set addrErr<=misaligned and regWrite<=inValid & inRegWrite & (inWriteReg!=0) & !misaligned.
REQ-028 SHALL never assert regWrite for writeReg=0.
REQ-029 On each capture edge with inValid=1 and misaligned=0, SHALL increment retired by 1, wrapping 0xFFFFFFFF->0.
REQ-030 Misaligned instructions and flushed or bubble (inValid=0) cycles SHALL NOT increment retired.
REQ-031 regWrite SHALL be high for the whole cycle(s) the instruction is held; a stalled write is re-presented each held cycle.

Reset
REQ-032 While rst_n=0, SHALL force regWrite=0, writeReg=0, writeData=0, wbValid=0, addrErr=0, retired=0, independent of clk.
REQ-033 Reset deassertion SHALL take effect at the next rising edge; an instruction in flight at reset assertion SHALL be discarded, not written.

Verification
REQ-034 ALU path: inValid=1, inRegWrite=1, inMemToReg=0, inWriteReg=5, inAluResult=0x0000_1234 -> next cycle regWrite=1, writeReg=5, writeData=0x0000_1234, retired=1.
REQ-035 Loads: inMemData=0x80FF_7F01; LB addrLow=3 -> 0xFFFF_FF80; LBU addrLow=2 -> 0x0000_00FF; LH addrLow=2 -> 0xFFFF_80FF; LHU addrLow=0 -> 0x0000_7F01.
REQ-036 Misaligned: LW addrLow=2, inWriteReg=8 -> addrErr=1, regWrite=0, wbValid=1, retired unchanged.
REQ-037 Hazards: stall=1 for 3 cycles with new inputs -> outputs and retired frozen; stall=1 and flush=1 same edge -> wbValid=0, regWrite=0.
REQ-038 Register zero: inWriteReg=0, inRegWrite=1 -> regWrite=0, retired still increments.
REQ-039 Reset/wrap: retired preloaded to 0xFFFF_FFFF via 2^32-1 retirements is impractical, so bench forces counter, retires one -> 0; assert rst_n=0 mid-cycle -> all outputs 0 before next edge.
